// File: rtl/debug_tx_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debug_tx_serializer_pkg
//  Description : Shared debug-unit definitions: word geometry defaults and
//                the transmit-serializer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package debug_tx_serializer_pkg;

    // Bytes per debug word unless a block overrides it (legal range 1..4)
    localparam int c_n_bytes_default = 4;

    // Width of a byte index; four bytes at most per word
    localparam int c_idx_w = 2;

    // Serializer states, explicit two-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_FINISH    = 2'd3
    } dbg_tx_state_e;

endpackage
`default_nettype wire

// File: rtl/debug_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : debug_tx_serializer
//  Description : Accepts debug words and feeds them one byte at a time to a
//                UART transmitter, handshaking on start/done pulses. Counts
//                bytes sent and flags the end of a dump after an i_last word.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_tx_serializer
    import debug_tx_serializer_pkg::*;
#(
    parameter int N_BYTES   = c_n_bytes_default,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*N_BYTES-1:0] i_word,
    input  logic                 i_word_valid,
    input  logic                 i_last,
    output logic                 o_word_ready,
    output logic [7:0]           o_tx_data,
    output logic                 os_tx_start,
    input  logic                 is_tx_done,
    output logic                 o_busy,
    output logic                 o_dump_done,
    output logic [15:0]          o_byte_count
);

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_BYTES - 1);

    dbg_tx_state_e          state_q;
    logic [8*N_BYTES-1:0]   word_q;
    logic                   last_q;
    logic [c_idx_w-1:0]     idx_q;
    logic [c_idx_w-1:0]     idx_d;
    logic [15:0]            count_q;
    logic [15:0]            count_d;
    logic                   word_ready_q;
    logic [7:0]             tx_data_q;
    logic                   tx_start_q;
    logic                   busy_q;
    logic                   dump_done_q;

    // Byte mux: map a transmit position to a byte lane, reversing the lane
    // order when the top byte must go out first.
    function automatic logic [7:0] pick_byte(input logic [8*N_BYTES-1:0] word,
                                             input logic [c_idx_w-1:0]   idx);
        logic [31:0]        wide;
        logic [c_idx_w-1:0] lane;
        logic [7:0]         b;
        wide = 32'(word);
        lane = MSB_FIRST ? (c_last_idx - idx) : idx;
        case (lane)
            2'd0:    b = wide[7:0];
            2'd1:    b = wide[15:8];
            2'd2:    b = wide[23:16];
            default: b = wide[31:24];
        endcase
        return b;
    endfunction

    // Next byte position and next count value
    always_comb begin
        idx_d   = idx_q + 1'b1;
        count_d = count_q + 16'd1;
    end

    // Serializer FSM; every output is registered and set on the transition
    // into the state that owns it, so pulses line up with their state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            last_q       <= 1'b0;
            idx_q        <= '0;
            count_q      <= 16'd0;
            word_ready_q <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            dump_done_q  <= 1'b0;
        end else begin
            tx_start_q  <= 1'b0;
            dump_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Ready rises one cycle after reset release and stays up
                    word_ready_q <= 1'b1;
                    if (i_word_valid && word_ready_q) begin
                        word_q       <= i_word;
                        last_q       <= i_last;
                        idx_q        <= '0;
                        tx_data_q    <= pick_byte(i_word, '0);
                        tx_start_q   <= 1'b1;
                        word_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_START;
                    end
                end
                ST_START: begin
                    // A done coincident with the start pulse belongs to no byte
                    state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (is_tx_done) begin
                        count_q <= count_d;
                        if (idx_q != c_last_idx) begin
                            idx_q      <= idx_d;
                            tx_data_q  <= pick_byte(word_q, idx_d);
                            tx_start_q <= 1'b1;
                            state_q    <= ST_START;
                        end else if (last_q) begin
                            dump_done_q <= 1'b1;
                            state_q     <= ST_FINISH;
                        end else begin
                            word_ready_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= ST_IDLE;
                        end
                    end
                end
                ST_FINISH: begin
                    // Dump complete: restart the byte tally for the next dump
                    count_q      <= 16'd0;
                    word_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_word_ready = word_ready_q;
    assign o_tx_data    = tx_data_q;
    assign os_tx_start  = tx_start_q;
    assign o_busy       = busy_q;
    assign o_dump_done  = dump_done_q;
    assign o_byte_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_tx_serializer
//  Description : Self-checking bench for debug_tx_serializer. Two instances
//                (LSB-first and MSB-first) share all inputs; expected bytes
//                and counts come from plain arithmetic on the sent words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_tx_serializer;

    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [8*NB-1:0] i_word = '0;
    logic            i_word_valid = 1'b0;
    logic            i_last = 1'b0;
    logic            is_tx_done = 1'b0;

    logic            l_ready, l_start, l_busy, l_dump;
    logic [7:0]      l_data;
    logic [15:0]     l_count;
    logic            m_ready, m_start, m_busy, m_dump;
    logic [7:0]      m_data;
    logic [15:0]     m_count;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [15:0]     mdl_count = 16'd0;
    bit              g_force_spur = 1'b0;

    debug_tx_serializer #(.N_BYTES(NB), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk          (clk),
        .rst          (rst),
        .i_word       (i_word),
        .i_word_valid (i_word_valid),
        .i_last       (i_last),
        .o_word_ready (l_ready),
        .o_tx_data    (l_data),
        .os_tx_start  (l_start),
        .is_tx_done   (is_tx_done),
        .o_busy       (l_busy),
        .o_dump_done  (l_dump),
        .o_byte_count (l_count)
    );

    debug_tx_serializer #(.N_BYTES(NB), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk          (clk),
        .rst          (rst),
        .i_word       (i_word),
        .i_word_valid (i_word_valid),
        .i_last       (i_last),
        .o_word_ready (m_ready),
        .o_tx_data    (m_data),
        .os_tx_start  (m_start),
        .is_tx_done   (is_tx_done),
        .o_busy       (m_busy),
        .o_dump_done  (m_dump),
        .o_byte_count (m_count)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any mismatch
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Byte sent at position i: byte lanes taken low-to-high, or high-to-low
    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i, input bit msb);
        int lane;
        lane = msb ? (NB - 1 - i) : i;
        return 8'((w >> (8 * lane)) & 32'hFF);
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready_l"}, l_ready, 0);   chk({tag, "_ready_m"}, m_ready, 0);
        chk({tag, "_busy_l"},  l_busy, 0);    chk({tag, "_busy_m"},  m_busy, 0);
        chk({tag, "_start_l"}, l_start, 0);   chk({tag, "_start_m"}, m_start, 0);
        chk({tag, "_data_l"},  l_data, 0);    chk({tag, "_data_m"},  m_data, 0);
        chk({tag, "_dump_l"},  l_dump, 0);    chk({tag, "_dump_m"},  m_dump, 0);
        chk({tag, "_count_l"}, l_count, 0);   chk({tag, "_count_m"}, m_count, 0);
    endtask

    // Idle cycles: nothing offered, optionally with done held high
    task automatic idle(input int n, input bit done_lvl);
        repeat (n) begin
            i_word_valid = 1'b0;
            is_tx_done   = done_lvl;
            @(negedge clk);
            chk("idle_ready", l_ready, 1);
            chk("idle_busy",  l_busy, 0);
            chk("idle_start", l_start, 0);
            chk("idle_count", l_count, mdl_count);
        end
    endtask

    // Send one word and check every cycle of its transmission. Called on a
    // negedge where ready is expected high; returns on a negedge where the
    // block is ready again. abort_at>0 resets the block after that many bytes.
    task automatic send_word(input logic [31:0] w, input bit last, input bit hold_valid,
                             input bit idle_done, input int abort_at, input int fixed_dly);
        int dly;
        bit spur;
        chk("pre_ready_l", l_ready, 1);
        chk("pre_ready_m", m_ready, 1);
        i_word       = w;
        i_last       = last;
        i_word_valid = 1'b1;
        is_tx_done   = idle_done;
        @(negedge clk);
        // After acceptance the inputs are garbage that must be ignored
        if (!hold_valid) i_word_valid = 1'b0;
        i_word = $urandom;
        i_last = 1'($urandom_range(0, 1));
        for (int i = 0; i < NB; i++) begin
            chk("start_l", l_start, 1);
            chk("start_m", m_start, 1);
            chk("data_l", l_data, exp_byte(w, i, 1'b0));
            chk("data_m", m_data, exp_byte(w, i, 1'b1));
            chk("busy_ready", l_ready, 0);
            chk("busy_flag", l_busy, 1);
            spur = g_force_spur ? 1'b1 : 1'($urandom_range(0, 1));
            is_tx_done = spur;
            dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 4));
            repeat (dly) begin
                @(negedge clk);
                is_tx_done = 1'b0;
                chk("wait_start", l_start, 0);
                chk("hold_data_l", l_data, exp_byte(w, i, 1'b0));
                chk("hold_data_m", m_data, exp_byte(w, i, 1'b1));
                chk("wait_count", l_count, mdl_count);
                chk("wait_ready", m_ready, 0);
            end
            is_tx_done = 1'b1;
            @(negedge clk);
            is_tx_done = 1'b0;
            mdl_count = mdl_count + 16'd1;
            chk("count_l", l_count, mdl_count);
            chk("count_m", m_count, mdl_count);
            if (abort_at == i + 1) begin
                i_word_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                mdl_count = 16'd0;
                chk_reset_vals("abort");
                @(negedge clk);
                chk("abort_ready_l", l_ready, 1);
                chk("abort_ready_m", m_ready, 1);
                return;
            end
        end
        chk("end_start", l_start, 0);
        is_tx_done = idle_done;
        if (!last) begin
            chk("end_ready", l_ready, 1);
            chk("end_busy",  l_busy, 0);
            chk("end_dump",  l_dump, 0);
        end else begin
            chk("dump_l", l_dump, 1);
            chk("dump_m", m_dump, 1);
            chk("dump_ready", l_ready, 0);
            chk("dump_busy", l_busy, 1);
            @(negedge clk);
            mdl_count = 16'd0;
            chk("dump_once_l", l_dump, 0);
            chk("dump_once_m", m_dump, 0);
            chk("dump_ready_after", l_ready, 1);
            chk("dump_busy_after", l_busy, 0);
            chk("dump_count_clr", l_count, 0);
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst_l", l_ready, 1);
        chk("ready_after_rst_m", m_ready, 1);
        mdl_count = 16'd0;

        // Default ordering, non-last word, done five cycles after each start
        send_word(32'h04030201, 1'b0, 1'b0, 1'b0, 0, 5);
        chk("count_four", l_count, 4);
        idle(2, 1'b0);

        // Last word: dump-done pulse and count cleared
        send_word(32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 0, 5);
        chk("count_zero_after_dump", m_count, 0);

        // Done held high in idle and coincident with every start pulse
        g_force_spur = 1'b1;
        idle(3, 1'b1);
        send_word(32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 0, 0);
        idle(2, 1'b1);
        g_force_spur = 1'b0;

        // Three back-to-back words with valid held high
        send_word(32'h13579BDF, 1'b0, 1'b1, 1'b0, 0, 0);
        send_word(32'h2468ACE0, 1'b0, 1'b1, 1'b0, 0, 0);
        send_word(32'h0F1E2D3C, 1'b0, 1'b1, 1'b0, 0, 0);
        i_word_valid = 1'b0;
        idle(1, 1'b0);

        // Reset mid-word, then a clean word with no residue
        send_word(32'hAABBCCDD, 1'b0, 1'b0, 1'b0, 2, 0);
        send_word(32'h11223344, 1'b0, 1'b0, 1'b0, 0, 0);
        idle(1, 1'b0);

        // Randomized words, gaps, last flags and done timing
        for (int k = 0; k < 40; k++) begin
            logic [31:0] w;
            bit          lst, hld, idn;
            w   = $urandom;
            lst = ($urandom_range(0, 3) == 0);
            hld = 1'($urandom_range(0, 1));
            idn = 1'($urandom_range(0, 1));
            send_word(w, lst, hld, idn, 0, 0);
            if (!hld) idle(int'($urandom_range(0, 2)), idn);
        end
        i_word_valid = 1'b0;
        idle(1, 1'b0);

        // Byte counter wrap: 65535 bytes then one more reads zero
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_count = 16'd0;
        @(negedge clk);
        for (int k = 0; k < 16384; k++) begin
            send_word($urandom, 1'b0, 1'b1, 1'b0, 0, 1);
        end
        i_word_valid = 1'b0;
        chk("count_wrap_l", l_count, 0);
        chk("count_wrap_m", m_count, 0);
        idle(1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
